// File: rtl/pool_pkg.sv
// pool_pkg: shared types and constants for the 2x2 pooling stage.
//   - FSM state enum for conv_maxpool_2x2
//   - byte / word / address widths
//   - words-per-row and pooled-pixel-count derivations from the input side
// Optional feature macro used by this slice: POOL_AVG_EN (see pool_reduce4).
package pool_pkg;

    localparam int BYTE_W      = 8;
    localparam int WORD_W      = 16;
    localparam int ADDR_W      = 12;
    localparam int POOL_IN_DIM = 14;

    // Two pixels per word, so one input row spans dim/2 words; the pooled
    // map is (dim/2) x (dim/2) pixels.
    function automatic int words_per_row(input int dim);
        return dim / 2;
    endfunction

    function automatic int pooled_count(input int dim);
        return (dim / 2) * (dim / 2);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_T,
        ST_ADDR_B,
        ST_CAP_T,
        ST_CAP_B,
        ST_WRITE,
        ST_DONE
    } pool_state_t;

endpackage

// File: rtl/pool_reduce4.sv
// pool_reduce4: combinational 2x2 window reduction.
// Ports:
//   i_a, i_b, i_c, i_d : four signed window bytes
//   o_y                : reduced signed byte
// Macro POOL_AVG_EN: defined -> floor average of the four bytes,
//                    undefined -> signed maximum.
module pool_reduce4
    import pool_pkg::*;
(
    input  logic signed [BYTE_W-1:0] i_a,
    input  logic signed [BYTE_W-1:0] i_b,
    input  logic signed [BYTE_W-1:0] i_c,
    input  logic signed [BYTE_W-1:0] i_d,
    output logic signed [BYTE_W-1:0] o_y
);

`ifdef POOL_AVG_EN
    // 10 bits hold the sum of four signed bytes without overflow.
    logic signed [BYTE_W+1:0] w_sum;
    logic signed [BYTE_W+1:0] w_shr;

    assign w_sum = {{2{i_a[BYTE_W-1]}}, i_a} + {{2{i_b[BYTE_W-1]}}, i_b}
                 + {{2{i_c[BYTE_W-1]}}, i_c} + {{2{i_d[BYTE_W-1]}}, i_d};
    assign w_shr = w_sum >>> 2;
    assign o_y   = w_shr[BYTE_W-1:0];
`else
    logic signed [BYTE_W-1:0] w_m01;
    logic signed [BYTE_W-1:0] w_m23;

    assign w_m01 = (i_a > i_b) ? i_a : i_b;
    assign w_m23 = (i_c > i_d) ? i_c : i_d;
    assign o_y   = (w_m01 > w_m23) ? w_m01 : w_m23;
`endif

endmodule

// File: rtl/conv_maxpool_2x2.sv
// conv_maxpool_2x2: reads a packed IN_DIM x IN_DIM signed-byte map from the
// output SRAM, reduces every non-overlapping 2x2 window and writes the packed
// pooled map to the scratchpad SRAM.
// Ports:
//   clk, reset_b                    clock, async active-low reset
//   pool_run / pool_busy            start request / pass in progress
//   output_sram_read_address/_data  read port, one-cycle read latency
//   scratchpad_sram_write_*         write strobe, address and data
// Macro POOL_AVG_EN selects average instead of max pooling (in pool_reduce4).
//
// state   | meaning
// IDLE    | waiting for pool_run
// ADDR_T  | register top-row word address
// ADDR_B  | register bottom-row word address
// CAP_T   | top word on the read bus, latch it
// CAP_B   | bottom word on the bus, reduce; park high byte or go write
// WRITE   | write strobe for one packed word
// DONE    | last word written, drop busy
module conv_maxpool_2x2
    import pool_pkg::*;
#(
    parameter int                IN_DIM   = POOL_IN_DIM,
    parameter logic [ADDR_W-1:0] IN_BASE  = 12'd0,
    parameter logic [ADDR_W-1:0] OUT_BASE = 12'd0
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              pool_run,
    output logic              pool_busy,
    output logic [ADDR_W-1:0] output_sram_read_address,
    input  logic [WORD_W-1:0] output_sram_read_data,
    output logic              scratchpad_sram_write_enable,
    output logic [ADDR_W-1:0] scratchpad_sram_write_addresss,
    output logic [WORD_W-1:0] scratchpad_sram_write_data
);

    localparam int                W      = words_per_row(IN_DIM);
    localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(W);
    localparam logic [ADDR_W-1:0] W2_A   = ADDR_W'(2 * W);
    localparam logic [ADDR_W-1:0] LAST_P = ADDR_W'(pooled_count(IN_DIM) - 1);

    pool_state_t       r_state;
    logic              r_busy;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_p;
    logic              r_slot;
    logic [BYTE_W-1:0] r_hi;
    logic [WORD_W-1:0] r_top;
    logic              r_we;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WORD_W-1:0] r_wr_data;

    logic              w_last;
    logic [BYTE_W-1:0] w_red;
    logic [ADDR_W-1:0] w_next_col;
    logic [ADDR_W-1:0] w_next_row_base;

    assign w_last = (r_p == LAST_P);

    // Column walk: wrapping the column skips the bottom row of the pair.
    assign w_next_col      = (r_col == W_A - 12'd1) ? '0 : r_col + 12'd1;
    assign w_next_row_base = (r_col == W_A - 12'd1) ? r_row_base + W2_A : r_row_base;

    pool_reduce4 u_reduce (
        .i_a (r_top[15:8]),
        .i_b (r_top[7:0]),
        .i_c (output_sram_read_data[15:8]),
        .i_d (output_sram_read_data[7:0]),
        .o_y (w_red)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_rd_addr  <= '0;
            r_row_base <= '0;
            r_col      <= '0;
            r_p        <= '0;
            r_slot     <= 1'b0;
            r_hi       <= '0;
            r_top      <= '0;
            r_we       <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (pool_run) begin
                        r_busy     <= 1'b1;
                        r_row_base <= IN_BASE;
                        r_col      <= '0;
                        r_p        <= '0;
                        r_slot     <= 1'b0;
                        r_wr_addr  <= OUT_BASE;
                        r_state    <= ST_ADDR_T;
                    end
                end
                ST_ADDR_T: begin
                    r_rd_addr <= r_row_base + r_col;
                    r_state   <= ST_ADDR_B;
                end
                ST_ADDR_B: begin
                    r_rd_addr <= r_row_base + r_col + W_A;
                    r_state   <= ST_CAP_T;
                end
                ST_CAP_T: begin
                    r_top   <= output_sram_read_data;
                    r_state <= ST_CAP_B;
                end
                ST_CAP_B: begin
                    if (!r_slot && !w_last) begin
                        r_hi       <= w_red;
                        r_slot     <= 1'b1;
                        r_p        <= r_p + 12'd1;
                        r_col      <= w_next_col;
                        r_row_base <= w_next_row_base;
                        r_state    <= ST_ADDR_T;
                    end else begin
                        // A lone last pixel lands in the high byte, low byte padded.
                        r_wr_data <= r_slot ? {r_hi, w_red} : {w_red, 8'h00};
                        r_we      <= 1'b1;
                        r_state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_wr_addr <= r_wr_addr + 12'd1;
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_p        <= r_p + 12'd1;
                        r_slot     <= 1'b0;
                        r_col      <= w_next_col;
                        r_row_base <= w_next_row_base;
                        r_state    <= ST_ADDR_T;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pool_busy                     = r_busy;
    assign output_sram_read_address      = r_rd_addr;
    assign scratchpad_sram_write_enable  = r_we;
    assign scratchpad_sram_write_addresss = r_wr_addr;
    assign scratchpad_sram_write_data    = r_wr_data;

endmodule

// File: doc/conv_maxpool_2x2.md
# conv_maxpool_2x2

Pooling stage directly downstream of the 3x3 convolution engine. Once the convolution engine has filled the output SRAM with a 14x14 map of signed 8-bit activations (two per 16-bit word, 7 words per row), this block reads that map. It reduces every non-overlapping 2x2 window to one byte, which gives a 7x7 map. It writes the packed result into the scratchpad SRAM for the next layer.

## Interface
Parameters:
- IN_DIM, 14: input map side in pixels; must be even, so words per row W = IN_DIM/2.
- IN_BASE, 12'd0: output-SRAM word address of input pixel (0,0).
- OUT_BASE, 12'd0: scratchpad word address of the first pooled word.

Ports:
- clk  in  1  the single clock, rising edge.
- reset_b  in  1  asynchronous active-low reset.
- pool_run  in  1  start request, sampled in IDLE only.
- pool_busy  out  1  high while a pooling pass is in progress.
- output_sram_read_address  out  12  registered read address.
- output_sram_read_data  in  16  {pixel 2k, pixel 2k+1}, high byte first.
- scratchpad_sram_write_enable  out  1  one-cycle write strobe.
- scratchpad_sram_write_addresss  out  12  write address.
- scratchpad_sram_write_data  out  16  {even pooled pixel, odd pooled pixel}.

## Operation
- SRAM read model: the address present on the port in cycle n returns data in cycle n+1.
- Pooled pixel p = r*W + c, with r, c in 0..W-1.
  - Top word address: IN_BASE + 2r*W + c.
  - Bottom word address: top + W.
  - The 2x2 window is {top[15:8], top[7:0], bot[15:8], bot[7:0]}.
- Reduction is the signed maximum of the four bytes. Ties have no effect because the value is identical.
- Packing:
  - Even p goes to the high byte; odd p goes to the low byte.
  - Word address is OUT_BASE + p/2.
  - With W*W odd, the final word holds the last pixel in the high byte and 8'h00 in the low byte.
- FSM:
  - IDLE: on pool_run go to ADDR_T.
  - ADDR_T: drive the top address; go to ADDR_B.
  - ADDR_B: drive the bottom address; go to CAP_T.
  - CAP_T: latch the top word; go to CAP_B.
  - CAP_B: latch the bottom word and reduce.
    - If the slot is the high byte and p is not the last pixel: store the byte, p++, go to ADDR_T.
    - Otherwise: go to WRITE.
  - WRITE: strobe write enable and increment the output word counter.
    - If p was the last pixel, go to DONE.
    - Otherwise p++ and go to ADDR_T.
  - DONE: drop pool_busy; go to IDLE.
- pool_run while busy is ignored. A held pool_run restarts a new pass after DONE returns to IDLE.
- Reset mid-pass:
  - Immediately clears all state and outputs.
  - Any partially assembled word is discarded and never written.

## Timing
- Reset values: pool_busy 0, all addresses 0, write data 0, write enable 0, FSM IDLE.
- pool_busy rises on the edge that samples pool_run in IDLE. It falls on the edge leaving DONE.
- Cycles per pass: 4*W*W + ceil(W*W/2) + 1. For IN_DIM=14 that is 196 + 25 + 1 = 222 cycles of busy.
- Write enable is high for exactly one cycle per word, with address and data stable in that same cycle.
- It is deasserted in every non-WRITE cycle.
- Exactly ceil(W*W/2) writes per pass (25 for the default). Writes go to consecutive addresses starting at OUT_BASE.
- The read address is never driven outside IN_BASE .. IN_BASE + IN_DIM*W - 1.

## Configuration
- POOL_AVG_EN defined: the reduction becomes average pooling.
  - Sign-extend the four bytes to 10 bits and sum them.
  - Arithmetic right-shift by 2 (floor), then truncate to 8 bits.
  - All timing is unchanged.
- POOL_AVG_EN undefined: signed 2x2 max pooling.

## Structure
- Shared package pool_pkg holds:
  - the FSM state enum;
  - byte/word width constants;
  - the words-per-row and pooled-count localparam derivations from IN_DIM.
- One sub-module, pool_reduce4: purely combinational, 4 signed bytes in, 1 signed byte out. POOL_AVG_EN selects max or average inside it.

## Test plan
- Reset with reset_b=0 mid-clock -> all outputs 0 asynchronously; pool_busy stays 0 with pool_run low.
- Output SRAM word0=16'h0102, word7=16'h0304, rest 0; pulse pool_run -> first write at address 0 with data high byte 8'h04; pool_busy high for 222 cycles.
- Window bytes {8'hFF, 8'hFE, 8'hFD, 8'h80}, rest 0, at p=0 -> scratchpad word0 high byte 8'hFF (signed max −1).
- Ramp data (byte value = pixel index mod 128) -> 25 writes to addresses 0..24; word24 = {pooled pixel 48, 8'h00}; every byte matches a reference-model max.
- Assert reset_b low at cycle 100 of a pass, release, pulse pool_run -> no write during reset, then a complete correct 25-word result.
- With POOL_AVG_EN:
  - Window {1,2,3,5} -> 8'h02.
  - Window {−1,−1,−1,−2} -> 8'hFE.
